lsu_align_fsm: RTL and testbench

LSU_ALIGN_FSM -- requirements
Module: lsu_align_fsm

---
 rtl/lsu_align_fsm.sv | 222 ++++++++++++++++++++++
 tb/tb_lsu_align_fsm.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align_fsm.sv
// Load/store alignment engine: turns byte/half/word and unaligned LWL/LWR/SWL/SWR ops into
// word-aligned memory requests with lane strobes, and merges load data for writeback.
module lsu_align_fsm #(
    parameter int unsigned ADDR_W      = 32,
    parameter bit          BIG_ENDIAN  = 1'b0,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_rt,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [31:0]       wb_data,
    output logic              wb_exc,
    output logic [ADDR_W-1:0] wb_badvaddr
);

    localparam logic [3:0] OpLb  = 4'd0;
    localparam logic [3:0] OpLbu = 4'd1;
    localparam logic [3:0] OpLh  = 4'd2;
    localparam logic [3:0] OpLhu = 4'd3;
    localparam logic [3:0] OpLw  = 4'd4;
    localparam logic [3:0] OpLwl = 4'd5;
    localparam logic [3:0] OpLwr = 4'd6;
    localparam logic [3:0] OpSb  = 4'd7;
    localparam logic [3:0] OpSh  = 4'd8;
    localparam logic [3:0] OpSw  = 4'd9;
    localparam logic [3:0] OpSwl = 4'd10;
    localparam logic [3:0] OpSwr = 4'd11;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [1:0]         ea_q, ea_d;
    logic [ADDR_W-3:0]  addr_q, addr_d;
    logic [31:0]        rt_q, rt_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic               wb_exc_q, wb_exc_d;
    logic [ADDR_W-1:0]  wb_bad_q, wb_bad_d;

    logic [1:0]  ea_in;
    logic        exc_in;
    logic        is_store;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign ea_in    = req_addr[1:0] ^ {2{BIG_ENDIAN}};
    assign is_store = (op_q >= OpSb) && (op_q <= OpSwr);

    always_comb begin
        exc_in = 1'b0;
        case (req_op)
            OpLh, OpLhu, OpSh: exc_in = ALIGN_CHECK && ea_in[0];
            OpLw, OpSw:        exc_in = ALIGN_CHECK && (ea_in != 2'b00);
            OpLb, OpLbu, OpLwl, OpLwr, OpSb, OpSwl, OpSwr: exc_in = 1'b0;
            default:           exc_in = 1'b1;
        endcase
    end

    always_comb begin
        st_strb  = 4'b0000;
        st_wdata = 32'h0;
        case (op_q)
            OpSb: begin
                st_strb  = 4'b0001 << ea_q;
                st_wdata = {4{rt_q[7:0]}};
            end
            OpSh: begin
                st_strb  = ea_q[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{rt_q[15:0]}};
            end
            OpSw: begin
                st_strb  = 4'b1111;
                st_wdata = rt_q;
            end
            OpSwl: begin
                case (ea_q)
                    2'd0:    begin st_strb = 4'b0001; st_wdata = {24'h0, rt_q[31:24]}; end
                    2'd1:    begin st_strb = 4'b0011; st_wdata = {16'h0, rt_q[31:16]}; end
                    2'd2:    begin st_strb = 4'b0111; st_wdata = {8'h0, rt_q[31:8]};   end
                    default: begin st_strb = 4'b1111; st_wdata = rt_q;                  end
                endcase
            end
            OpSwr: begin
                case (ea_q)
                    2'd0:    begin st_strb = 4'b1111; st_wdata = rt_q;                  end
                    2'd1:    begin st_strb = 4'b1110; st_wdata = {rt_q[23:0], 8'h0};   end
                    2'd2:    begin st_strb = 4'b1100; st_wdata = {rt_q[15:0], 16'h0};  end
                    default: begin st_strb = 4'b1000; st_wdata = {rt_q[7:0], 24'h0};   end
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ea_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = ea_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = mem_rdata;
        case (op_q)
            OpLb:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            OpLbu: ld_data = {24'h0, ld_byte};
            OpLh:  ld_data = {{16{ld_half[15]}}, ld_half};
            OpLhu: ld_data = {16'h0, ld_half};
            OpLwl: begin
                case (ea_q)
                    2'd0:    ld_data = {mem_rdata[7:0], rt_q[23:0]};
                    2'd1:    ld_data = {mem_rdata[15:0], rt_q[15:0]};
                    2'd2:    ld_data = {mem_rdata[23:0], rt_q[7:0]};
                    default: ld_data = mem_rdata;
                endcase
            end
            OpLwr: begin
                case (ea_q)
                    2'd0:    ld_data = mem_rdata;
                    2'd1:    ld_data = {rt_q[31:24], mem_rdata[31:8]};
                    2'd2:    ld_data = {rt_q[31:16], mem_rdata[31:16]};
                    default: ld_data = {rt_q[31:8], mem_rdata[31:24]};
                endcase
            end
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        ea_d          = ea_q;
        addr_d        = addr_q;
        rt_d          = rt_q;
        wb_data_d     = wb_data_q;
        wb_exc_d      = wb_exc_q;
        wb_bad_d      = wb_bad_q;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        wb_valid      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Gated by rst so the handshake is closed while reset is held.
                req_ready = !rst;
                if (req_valid) begin
                    op_d      = req_op;
                    ea_d      = ea_in;
                    addr_d    = req_addr[ADDR_W-1:2];
                    rt_d      = req_rt;
                    wb_data_d = 32'h0;
                    wb_exc_d  = exc_in;
                    wb_bad_d  = exc_in ? req_addr : '0;
                    state_d   = exc_in ? StResp : StReq;
                end
            end
            StReq: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = is_store ? StResp : StWait;
            end
            StWait: begin
                if (mem_rsp_valid) begin
                    wb_data_d = ld_data;
                    state_d   = StResp;
                end
            end
            StResp: begin
                wb_valid = 1'b1;
                if (wb_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= 4'h0;
            ea_q      <= 2'b00;
            addr_q    <= '0;
            rt_q      <= 32'h0;
            wb_data_q <= 32'h0;
            wb_exc_q  <= 1'b0;
            wb_bad_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            ea_q      <= ea_d;
            addr_q    <= addr_d;
            rt_q      <= rt_d;
            wb_data_q <= wb_data_d;
            wb_exc_q  <= wb_exc_d;
            wb_bad_q  <= wb_bad_d;
        end
    end

    // Memory-side payload is only driven while the request is being offered.
    assign mem_addr    = (state_q == StReq) ? {addr_q, 2'b00} : '0;
    assign mem_wen     = (state_q == StReq) && is_store;
    assign mem_wstrb   = mem_wen ? st_strb : 4'b0000;
    assign mem_wdata   = mem_wen ? st_wdata : 32'h0;
    assign wb_data     = wb_data_q;
    assign wb_exc      = wb_exc_q;
    assign wb_badvaddr = wb_bad_q;

endmodule

// File: tb/tb_lsu_align_fsm.sv
// Scoreboard bench for lsu_align_fsm: three instances (LE, BE, no align check) share stimulus,
// one is selected at a time; expectations come from an independent reference model.
module tb_lsu_align_fsm;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] rdata;
        int          mstall;
        int          wstall;
    } stim_t;

    typedef struct packed {
        logic        exc;
        logic [31:0] data;
        logic [31:0] bad;
        logic        mem;
        logic [31:0] maddr;
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } exp_t;

    typedef struct packed {
        logic        mem_seen;
        logic [31:0] maddr;
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          mem_cyc;
        logic        wb_seen;
        logic [31:0] data;
        logic        exc;
        logic [31:0] bad;
        int          wb_cyc;
        logic        unstable;
        logic        excl_bad;
        logic        rdy_bad;
        logic        extra;
        logic        idle_ok;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_rt;
    logic        mem_req_ready, mem_rsp_valid, wb_ready;
    logic [31:0] mem_rdata;
    int          sel;

    logic        rr[3], mrv[3], wen[3], wbv[3], wbx[3];
    logic [31:0] ma[3], wd[3], wbd[3], wbb[3];
    logic [3:0]  stb[3];

    logic        req_ready, mem_req_valid, mem_wen, wb_valid, wb_exc;
    logic [31:0] mem_addr, mem_wdata, wb_data, wb_badvaddr;
    logic [3:0]  mem_wstrb;

    stim_t stim_q[$];
    exp_t  sb_q[$];
    int    checks = 0;
    int    passes = 0;

    always #5 clk = ~clk;

    lsu_align_fsm #(.ADDR_W(32), .BIG_ENDIAN(1'b0), .ALIGN_CHECK(1'b1)) u_le (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel == 0), .req_ready(rr[0]),
        .req_op(req_op), .req_addr(req_addr), .req_rt(req_rt),
        .mem_req_valid(mrv[0]), .mem_req_ready(mem_req_ready), .mem_addr(ma[0]),
        .mem_wen(wen[0]), .mem_wstrb(stb[0]), .mem_wdata(wd[0]),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .wb_valid(wbv[0]), .wb_ready(wb_ready), .wb_data(wbd[0]), .wb_exc(wbx[0]),
        .wb_badvaddr(wbb[0]));

    lsu_align_fsm #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .ALIGN_CHECK(1'b1)) u_be (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel == 1), .req_ready(rr[1]),
        .req_op(req_op), .req_addr(req_addr), .req_rt(req_rt),
        .mem_req_valid(mrv[1]), .mem_req_ready(mem_req_ready), .mem_addr(ma[1]),
        .mem_wen(wen[1]), .mem_wstrb(stb[1]), .mem_wdata(wd[1]),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .wb_valid(wbv[1]), .wb_ready(wb_ready), .wb_data(wbd[1]), .wb_exc(wbx[1]),
        .wb_badvaddr(wbb[1]));

    lsu_align_fsm #(.ADDR_W(32), .BIG_ENDIAN(1'b0), .ALIGN_CHECK(1'b0)) u_na (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel == 2), .req_ready(rr[2]),
        .req_op(req_op), .req_addr(req_addr), .req_rt(req_rt),
        .mem_req_valid(mrv[2]), .mem_req_ready(mem_req_ready), .mem_addr(ma[2]),
        .mem_wen(wen[2]), .mem_wstrb(stb[2]), .mem_wdata(wd[2]),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .wb_valid(wbv[2]), .wb_ready(wb_ready), .wb_data(wbd[2]), .wb_exc(wbx[2]),
        .wb_badvaddr(wbb[2]));

    always_comb begin
        req_ready     = rr[sel];
        mem_req_valid = mrv[sel];
        mem_addr      = ma[sel];
        mem_wen       = wen[sel];
        mem_wstrb     = stb[sel];
        mem_wdata     = wd[sel];
        wb_valid      = wbv[sel];
        wb_data       = wbd[sel];
        wb_exc        = wbx[sel];
        wb_badvaddr   = wbb[sel];
    end

    function automatic logic [31:0] lane_mask(input logic [3:0] st);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{st[i]}};
        return m;
    endfunction

    function automatic exp_t model(input stim_t s, input bit be, input bit ac);
        exp_t        e;
        logic [1:0]  ea;
        int          k;
        logic [7:0]  b;
        logic [15:0] h;
        e  = '0;
        ea = s.addr[1:0] ^ {be, be};
        k  = int'(ea);
        if (s.op >= 4'd12) e.exc = 1'b1;
        else if (ac && (s.op == 4'd2 || s.op == 4'd3 || s.op == 4'd8) && ea[0]) e.exc = 1'b1;
        else if (ac && (s.op == 4'd4 || s.op == 4'd9) && ea != 2'b00) e.exc = 1'b1;
        if (e.exc) begin
            e.bad = s.addr;
            return e;
        end
        e.mem   = 1'b1;
        e.maddr = s.addr & ~32'h3;
        if (s.op >= 4'd7) begin
            e.wen = 1'b1;
            case (s.op)
                4'd7:  begin e.strb = 4'b0001 << k; e.wdata = {24'h0, s.rt[7:0]} << (8*k); end
                4'd8:  begin
                    e.strb  = ea[1] ? 4'b1100 : 4'b0011;
                    e.wdata = {16'h0, s.rt[15:0]} << (16*int'(ea[1]));
                end
                4'd9:  begin e.strb = 4'b1111; e.wdata = s.rt; end
                4'd10: begin e.strb = 4'b1111 >> (3-k); e.wdata = s.rt >> (8*(3-k)); end
                default: begin e.strb = 4'b1111 << k; e.wdata = s.rt << (8*k); end
            endcase
            e.wdata = e.wdata & lane_mask(e.strb);
        end else begin
            b = 8'(s.rdata >> (8*k));
            h = 16'(s.rdata >> (16*int'(ea[1])));
            case (s.op)
                4'd0: e.data = {{24{b[7]}}, b};
                4'd1: e.data = {24'h0, b};
                4'd2: e.data = {{16{h[15]}}, h};
                4'd3: e.data = {16'h0, h};
                4'd4: e.data = s.rdata;
                4'd5: e.data = (s.rdata << (8*(3-k))) | (s.rt & ((32'h1 << (8*(3-k))) - 32'h1));
                default: e.data = (s.rdata >> (8*k)) | (s.rt & ~(32'hFFFF_FFFF >> (8*k)));
            endcase
        end
        return e;
    endfunction

    // Offers one op, plays the memory and writeback sides, and records what the DUT did.
    task automatic drive_op(input stim_t s, output obs_t o);
        int  hs_cyc;
        int  bud;
        bit  done;
        o = '0;
        hs_cyc = -10;
        done = 1'b0;
        bud = 0;
        while (!req_ready && bud < 50) begin
            @(negedge clk);
            bud++;
        end
        req_valid = 1'b1;
        req_op    = s.op;
        req_addr  = s.addr;
        req_rt    = s.rt;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_addr  = $urandom;
        req_rt    = $urandom;
        for (int c = 1; c < 100; c++) begin
            if (mem_req_valid && wb_valid) o.excl_bad = 1'b1;
            if (req_ready) o.rdy_bad = 1'b1;
            mem_req_ready = 1'b0;
            wb_ready      = 1'b0;
            mem_rsp_valid = o.mem_seen && !o.wen && (c == hs_cyc + 2);
            mem_rdata     = mem_rsp_valid ? s.rdata : $urandom;
            if (mem_req_valid) begin
                if (!o.mem_seen) begin
                    o.mem_seen = 1'b1;
                    o.mem_cyc  = c;
                    o.maddr    = mem_addr;
                    o.wen      = mem_wen;
                    o.strb     = mem_wstrb;
                    o.wdata    = mem_wdata;
                end else if ({mem_addr, mem_wen, mem_wstrb, mem_wdata} !==
                             {o.maddr, o.wen, o.strb, o.wdata}) begin
                    o.unstable = 1'b1;
                end
                if (c - o.mem_cyc >= s.mstall) begin
                    mem_req_ready = 1'b1;
                    hs_cyc = c;
                end
            end
            if (wb_valid) begin
                if (!o.wb_seen) begin
                    o.wb_seen = 1'b1;
                    o.wb_cyc  = c;
                    o.data    = wb_data;
                    o.exc     = wb_exc;
                    o.bad     = wb_badvaddr;
                end else if ({wb_data, wb_exc, wb_badvaddr} !== {o.data, o.exc, o.bad}) begin
                    o.unstable = 1'b1;
                end
                if (c - o.wb_cyc >= s.wstall) begin
                    wb_ready = 1'b1;
                    done = 1'b1;
                end
            end
            @(negedge clk);
            if (done) break;
        end
        mem_req_ready = 1'b0;
        wb_ready      = 1'b0;
        mem_rsp_valid = 1'b0;
        o.wb_seen = done;
        o.extra   = wb_valid;
        o.idle_ok = req_ready;
    endtask

    task automatic run_and_score(input int d, input bit be, input bit ac);
        stim_t s;
        exp_t  e;
        obs_t  o;
        int    exp_wb;
        sel = d;
        #1;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            sb_q.push_back(model(s, be, ac));
            drive_op(s, o);
            e = sb_q.pop_front();
            checks++;
            if (!o.wb_seen) begin
                $display("FAIL completion dut=%0d op=%0d addr=%h: got none want wb_valid",
                         d, s.op, s.addr);
                continue;
            end
            passes++;
            checks++;
            if (o.exc !== e.exc || o.bad !== e.bad || o.data !== e.data)
                $display("FAIL wb_payload dut=%0d op=%0d addr=%h: got exc=%b bad=%h data=%h want exc=%b bad=%h data=%h",
                         d, s.op, s.addr, o.exc, o.bad, o.data, e.exc, e.bad, e.data);
            else passes++;
            checks++;
            if (o.mem_seen !== e.mem)
                $display("FAIL mem_request dut=%0d op=%0d addr=%h: got %b want %b",
                         d, s.op, s.addr, o.mem_seen, e.mem);
            else passes++;
            if (e.mem && o.mem_seen) begin
                checks++;
                if (o.maddr !== e.maddr || o.wen !== e.wen || o.strb !== e.strb ||
                    (o.wdata & lane_mask(e.strb)) !== e.wdata || o.mem_cyc != 1)
                    $display("FAIL mem_payload dut=%0d op=%0d addr=%h: got a=%h w=%b s=%b d=%h c=%0d want a=%h w=%b s=%b d=%h c=1",
                             d, s.op, s.addr, o.maddr, o.wen, o.strb, o.wdata, o.mem_cyc,
                             e.maddr, e.wen, e.strb, e.wdata);
                else passes++;
            end
            exp_wb = e.exc ? 1 : 1 + s.mstall + (e.wen ? 1 : 3);
            checks++;
            if (o.wb_cyc != exp_wb)
                $display("FAIL latency dut=%0d op=%0d addr=%h: got cycle %0d want %0d",
                         d, s.op, s.addr, o.wb_cyc, exp_wb);
            else passes++;
            checks++;
            if (o.unstable || o.excl_bad || o.rdy_bad || o.extra || !o.idle_ok)
                $display("FAIL protocol dut=%0d op=%0d addr=%h: got unst=%b excl=%b rdy=%b extra=%b idle=%b want 0 0 0 0 1",
                         d, s.op, s.addr, o.unstable, o.excl_bad, o.rdy_bad, o.extra, o.idle_ok);
            else passes++;
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] rdata, input int ms, input int ws);
        stim_t s;
        s.op = op; s.addr = addr; s.rt = rt; s.rdata = rdata; s.mstall = ms; s.wstall = ws;
        stim_q.push_back(s);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            checks++;
            if ({req_ready, mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata,
                 wb_valid, wb_data, wb_exc, wb_badvaddr} !== 137'h0)
                $display("FAIL reset_outputs dut=%0d: got rdy=%b mrv=%b a=%h wbv=%b d=%h want all 0",
                         d, req_ready, mem_req_valid, mem_addr, wb_valid, wb_data);
            else passes++;
        end
        sel = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", req_ready);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_le_ops();
        push(4'd0,  32'h1003, 32'h0,         32'h80FF_FF00, 0, 0);
        push(4'd1,  32'h1001, 32'h0,         32'h1234_F678, 0, 0);
        push(4'd2,  32'h2002, 32'h0,         32'h8001_7FFF, 0, 0);
        push(4'd3,  32'h2000, 32'h0,         32'h8001_F00F, 0, 0);
        push(4'd4,  32'h3000, 32'h0,         32'hDEAD_BEEF, 0, 0);
        push(4'd5,  32'h0001, 32'h1122_3344, 32'hAABB_CCDD, 0, 0);
        push(4'd6,  32'h0003, 32'h1122_3344, 32'hAABB_CCDD, 0, 0);
        push(4'd5,  32'h0002, 32'h1122_3344, 32'hAABB_CCDD, 0, 0);
        push(4'd6,  32'h0000, 32'h1122_3344, 32'hAABB_CCDD, 0, 0);
        push(4'd7,  32'h4002, 32'h0000_00A5, 32'h0,         0, 0);
        push(4'd8,  32'h4002, 32'h0000_BEEF, 32'h0,         0, 0);
        push(4'd9,  32'h4004, 32'hCAFE_F00D, 32'h0,         0, 0);
        push(4'd10, 32'h4001, 32'h1122_3344, 32'h0,         0, 0);
        push(4'd11, 32'h4002, 32'h1122_3344, 32'h0,         0, 0);
        push(4'd13, 32'h0050, 32'h0,         32'h0,         0, 0);
        push(4'd4,  32'h0006, 32'h0,         32'h0,         0, 0);
        push(4'd8,  32'h4001, 32'h0,         32'h0,         0, 0);
        run_and_score(0, 1'b0, 1'b1);
    endtask

    task automatic test_big_endian();
        push(4'd7,  32'h2000, 32'h0000_00AB, 32'h0,         0, 0);
        push(4'd0,  32'h2000, 32'h0,         32'hAB00_0000, 0, 0);
        push(4'd8,  32'h2001, 32'h0000_1234, 32'h0,         0, 0);
        push(4'd8,  32'h2000, 32'h0000_1234, 32'h0,         0, 0);
        push(4'd5,  32'h0000, 32'h1122_3344, 32'hAABB_CCDD, 0, 0);
        push(4'd11, 32'h0003, 32'h1122_3344, 32'h0,         0, 0);
        run_and_score(1, 1'b1, 1'b1);
    endtask

    task automatic test_no_align();
        push(4'd4, 32'h0006, 32'h0, 32'h0102_0304, 0, 0);
        push(4'd2, 32'h0001, 32'h0, 32'h0102_8304, 0, 0);
        push(4'd9, 32'h0013, 32'h5566_7788, 32'h0, 0, 0);
        run_and_score(2, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        push(4'd4, 32'h0080, 32'h0,         32'h1357_9BDF, 5, 3);
        push(4'd9, 32'h0084, 32'hA5A5_5A5A, 32'h0,         5, 3);
        push(4'd12, 32'h0088, 32'h0,        32'h0,         0, 3);
        run_and_score(0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++)
            push(4'($urandom_range(0, 12)), $urandom & 32'hFFFF, $urandom, $urandom,
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        run_and_score(0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        bit seen;
        int bud;
        sel = 0;
        #1;
        req_valid = 1'b1; req_op = 4'd4; req_addr = 32'h40; req_rt = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        bud = 0;
        while (!mem_req_valid && bud < 20) begin @(negedge clk); bud++; end
        checks++;
        if (!mem_req_valid) $display("FAIL reset_mid_request: got no mem_req_valid want 1");
        else passes++;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, mem_req_valid, wb_valid, mem_wen, wb_data} !== 36'h0)
            $display("FAIL reset_async: got rdy=%b mrv=%b wbv=%b wen=%b d=%h want all 0",
                     req_ready, mem_req_valid, wb_valid, mem_wen, wb_data);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'hFEED_FACE;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (wb_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen || !req_ready)
            $display("FAIL reset_abandon: got wb_valid=%b req_ready=%b want 0 1", seen, req_ready);
        else passes++;
        push(4'd4, 32'h0044, 32'h0, 32'h2468_ACE0, 0, 0);
        run_and_score(0, 1'b0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        sel = 0;
        req_valid = 1'b0; req_op = 4'h0; req_addr = 32'h0; req_rt = 32'h0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0; wb_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_le_ops();
        test_big_endian();
        test_no_align();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
